// File: rtl/rgb_led_seq_pkg.sv
// Shared types and channel indices for the RGB LED sequencer.
package rgb_led_seq_pkg;
  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_SOLID   = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    S_OFF, S_LOAD, S_SOLID, S_BLINK_ON, S_BLINK_OFF, S_BREATHE_UP, S_BREATHE_DOWN
  } state_t;

  localparam int CH_R   = 0;
  localparam int CH_G   = 1;
  localparam int CH_B   = 2;
  localparam int NUM_CH = 3;
endpackage

// File: rtl/rgb_pwm_channel.sv
// One LED channel: optional square-law gamma stage (RGB_LED_SEQ_GAMMA_EN),
// PWM compare and registered active-low pad drive.
module rgb_pwm_channel #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk_in,
  input  logic                rst_n,
  input  logic [PWM_BITS-1:0] i_duty,
  input  logic [PWM_BITS-1:0] i_pwm_cnt,
  output logic                o_led_n
);
  logic [PWM_BITS-1:0] w_duty;

`ifdef RGB_LED_SEQ_GAMMA_EN
  logic [2*PWM_BITS-1:0] w_ext;
  logic [2*PWM_BITS-1:0] w_sq;
  logic [PWM_BITS-1:0]   r_duty_g;

  assign w_ext = {{PWM_BITS{1'b0}}, i_duty};
  assign w_sq  = w_ext * w_ext;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) r_duty_g <= '0;
    else        r_duty_g <= w_sq[2*PWM_BITS-1:PWM_BITS];
  end
  assign w_duty = r_duty_g;
`else
  assign w_duty = i_duty;
`endif

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) o_led_n <= 1'b1;
    else        o_led_n <= ~(w_duty > i_pwm_cnt);
  end
endmodule

// File: rtl/rgb_led_seq.sv
// RGB LED sequencer: OFF / SOLID / BLINK / BREATHE driven by a valid/ready
// command port. Define RGB_LED_SEQ_GAMMA_EN for square-law duty correction.
module rgb_led_seq
  import rgb_led_seq_pkg::*;
#(
  parameter int PWM_BITS         = 8,
  parameter int TICK_DIV         = 46875,
  parameter int BLINK_HALF_TICKS = 128
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_mode,
  input  logic [3*PWM_BITS-1:0] cmd_color,
  output logic [1:0]            mode_o,
  output logic [2:0]            rgb
);
  localparam int PRE_W = $clog2(TICK_DIV + 1);
  localparam int HT_W  = $clog2(BLINK_HALF_TICKS + 1);
  localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [HT_W-1:0]     HALF_LAST = HT_W'(BLINK_HALF_TICKS - 1);
  localparam logic [PWM_BITS-1:0] LVL_TOP   = '1;
  localparam logic [PWM_BITS-1:0] LVL_ONE   = PWM_BITS'(1);

  state_t                r_state;
  mode_t                 r_mode;
  logic [3*PWM_BITS-1:0] r_color;
  logic [PWM_BITS-1:0]   r_level;
  logic [PWM_BITS-1:0]   r_pwm;
  logic [PRE_W-1:0]      r_presc;
  logic [HT_W-1:0]       r_tcnt;
  logic                  w_accept;
  logic                  w_tick;

  assign w_accept = cmd_valid & cmd_ready;
  assign w_tick   = (r_presc == PRE_LAST);

  // Timebase is held at zero through LOAD so every sequence starts phase-aligned.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_pwm   <= '0;
    end else if (w_accept || r_state == S_LOAD) begin
      r_presc <= '0;
      r_pwm   <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      r_pwm   <= r_pwm + 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_OFF;
      r_mode    <= MODE_OFF;
      r_color   <= '0;
      r_level   <= '0;
      r_tcnt    <= '0;
      cmd_ready <= 1'b1;
      mode_o    <= 2'd0;
    end else if (w_accept) begin
      r_state   <= S_LOAD;
      r_mode    <= mode_t'(cmd_mode);
      r_color   <= cmd_color;
      r_level   <= '0;
      r_tcnt    <= '0;
      cmd_ready <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          cmd_ready <= 1'b1;
          mode_o    <= r_mode;
          case (r_mode)
            MODE_SOLID:   r_state <= S_SOLID;
            MODE_BLINK:   r_state <= S_BLINK_ON;
            MODE_BREATHE: r_state <= S_BREATHE_UP;
            default:      r_state <= S_OFF;
          endcase
        end
        S_BLINK_ON, S_BLINK_OFF: if (w_tick) begin
          if (r_tcnt == HALF_LAST) begin
            r_tcnt  <= '0;
            r_state <= (r_state == S_BLINK_ON) ? S_BLINK_OFF : S_BLINK_ON;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        S_BREATHE_UP: if (w_tick) begin
          r_level <= r_level + 1'b1;
          if (r_level == LVL_TOP - LVL_ONE) r_state <= S_BREATHE_DOWN;
        end
        S_BREATHE_DOWN: if (w_tick) begin
          r_level <= r_level - 1'b1;
          if (r_level == LVL_ONE) r_state <= S_BREATHE_UP;
        end
        default: ;
      endcase
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [PWM_BITS-1:0]   w_col;
    logic [2*PWM_BITS-1:0] w_prod;
    logic [PWM_BITS-1:0]   w_duty;

    // Colour word is {R,G,B} with R in the MSBs; channel index 0 is R.
    assign w_col  = r_color[(NUM_CH-1-c)*PWM_BITS +: PWM_BITS];
    assign w_prod = {{PWM_BITS{1'b0}}, w_col} * {{PWM_BITS{1'b0}}, r_level};

    always_comb begin
      case (r_state)
        S_SOLID, S_BLINK_ON:          w_duty = w_col;
        S_BREATHE_UP, S_BREATHE_DOWN: w_duty = w_prod[2*PWM_BITS-1:PWM_BITS];
        default:                      w_duty = '0;
      endcase
    end

    rgb_pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch (
      .clk_in    (clk_in),
      .rst_n     (rst_n),
      .i_duty    (w_duty),
      .i_pwm_cnt (r_pwm),
      .o_led_n   (rgb[c])
    );
  end
endmodule
